// File: rtl/bintobcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the double-dabble adjust constants.
package bintobcd_pkg;

   typedef enum logic [1:0] {
      e_idle,
      e_operation,
      e_done
   } t_state;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5.
// Ports: digit (4-bit in), adjusted (4-bit out). Purely combinational.
module bcd_digit_adj
   import bintobcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD
                                               : digit;

endmodule

// File: rtl/bintobcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), start/ready/done.
// Ports: i_clk, i_rst (async high), i_start, i_bin[W], o_ready, o_done,
//        o_bcd[4*D] (digit 0 = units), o_overflow (saturated to all 9s).
module bintobcd_seq
   import bintobcd_pkg::*;
#(
   parameter int W = 14,
   parameter int D = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   input  logic [W-1:0]   i_bin,
   output logic           o_ready,
   output logic           o_done,
   output logic [4*D-1:0] o_bcd,
   output logic           o_overflow
);

   localparam int IW = $clog2(W+1);

   t_state         state;
   t_state         state_nxt;
   logic [IW-1:0]  index;
   logic [W-1:0]   bin_sr;
   logic [4*D-1:0] work;
   logic [4*D-1:0] adj;
   logic           ovf_sticky;

   for (genvar g = 0; g < D; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (work[4*g +: 4]),
         .adjusted (adj[4*g +: 4])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= e_idle;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_done    = 1'b0;
      unique case (state)
         e_idle: begin
            o_ready = 1'b1;
            if (i_start) state_nxt = e_operation;
         end
         e_operation: begin
            if (index == '0) state_nxt = e_done;
         end
         e_done: begin
            o_done    = 1'b1;
            state_nxt = e_idle;
         end
         default: state_nxt = e_idle;
      endcase
   end

   // Once the adjusted top digit has its MSB set the value has reached
   // 10^D; that bit falls off the shift and the result is saturated.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         index      <= '0;
         bin_sr     <= '0;
         work       <= '0;
         ovf_sticky <= 1'b0;
         o_bcd      <= '0;
         o_overflow <= 1'b0;
      end else begin
         unique case (state)
            e_idle: begin
               if (i_start) begin
                  bin_sr     <= i_bin;
                  work       <= '0;
                  ovf_sticky <= 1'b0;
                  index      <= IW'(W);
               end
            end
            e_operation: begin
               if (index != '0) begin
                  {work, bin_sr} <= {adj[4*D-2:0], bin_sr, 1'b0};
                  if (adj[4*D-1]) ovf_sticky <= 1'b1;
                  index <= index - IW'(1);
               end else begin
                  o_bcd      <= ovf_sticky ? {D{4'h9}} : work;
                  o_overflow <= ovf_sticky;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bintobcd_seq.sv
// Self-checking bench for bintobcd_seq (W=14, D=4) using a result queue.
// Expected results are pushed at start and popped on each o_done.
module tb_bintobcd_seq;

   localparam int W = 14;
   localparam int D = 4;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  bin;
   logic          ready;
   logic          done;
   logic [15:0]   bcd;
   logic          ovf;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   bintobcd_seq #(.W(W), .D(D)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_bin      (bin),
      .o_ready    (ready),
      .o_done     (done),
      .o_bcd      (bcd),
      .o_overflow (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input int v);
      exp_t e;
      int   t;
      if (v >= 10000) begin
         e.bcd = 16'h9999;
         e.ovf = 1'b1;
      end else begin
         t = v;
         e.bcd = '0;
         for (int k = 0; k < 4; k++) begin
            e.bcd[4*k +: 4] = 4'(t % 10);
            t = t / 10;
         end
         e.ovf = 1'b0;
      end
      return e;
   endfunction

   // Start one conversion and wait (bounded) for its done cycle.
   task automatic run(input int v, output int lat, output bit to);
      @(negedge clk);
      bin   = W'(v);
      start = 1'b1;
      q.push_back(model(v));
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      to = !done;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(negedge clk);
      total++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs ready=%b done=%b need 1/0", ready, done);
      end
      total++;
      if (bcd !== 16'h0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_out bcd=%h ovf=%b need 0000/0", bcd, ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero();
      exp_t e;
      @(negedge clk);
      bin   = '0;
      start = 1'b1;
      q.push_back(model(0));
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start = 1'b0;
         total++;
         if (ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_ready c=%0d got=%b need 0", c, ready);
         end
         total++;
         if (done !== (c == 16)) begin
            bad++;
            $display("FAIL zero_done c=%0d got=%b need %b", c, done, c == 16);
         end
         if (c == 16 && done) begin
            e = q.pop_front();
            total++;
            if (bcd !== e.bcd || ovf !== e.ovf) begin
               bad++;
               $display("FAIL zero_res got=%h/%b need %h/%b",
                        bcd, ovf, e.bcd, e.ovf);
            end
         end
      end
      @(negedge clk);
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_idle ready=%b need 1", ready);
      end
   endtask

   task automatic test_values();
      int  vals[5] = '{1234, 9999, 10000, 16383, 42};
      int  lat;
      bit  to;
      exp_t e;
      foreach (vals[i]) begin
         run(vals[i], lat, to);
         total++;
         if (to) begin
            bad++;
            $display("FAIL val_timeout v=%0d", vals[i]);
            void'(q.pop_front());
         end else begin
            e = q.pop_front();
            if (bcd !== e.bcd || ovf !== e.ovf) begin
               bad++;
               $display("FAIL val v=%0d got=%h/%b need %h/%b",
                        vals[i], bcd, ovf, e.bcd, e.ovf);
            end
            total++;
            if (lat !== 16) begin
               bad++;
               $display("FAIL val_lat v=%0d got=%0d need 16", vals[i], lat);
            end
         end
      end
   endtask

   task automatic test_ignore_start();
      int   dones = 0;
      exp_t e;
      @(negedge clk);
      bin   = 14'd7;
      start = 1'b1;
      q.push_back(model(7));
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = (c == 3 || c == 10);
         bin   = 14'd55;
         if (c == 5) begin
            total++;
            if (bcd !== 16'h0042 || ovf !== 1'b0) begin
               bad++;
               $display("FAIL hold got=%h/%b need 0042/0", bcd, ovf);
            end
         end
         if (done) begin
            dones++;
            total++;
            if (c !== 16) begin
               bad++;
               $display("FAIL ign_lat got=%0d need 16", c);
            end
            if (q.size() > 0) begin
               e = q.pop_front();
               total++;
               if (bcd !== e.bcd || ovf !== e.ovf) begin
                  bad++;
                  $display("FAIL ign_res got=%h/%b need %h/%b",
                           bcd, ovf, e.bcd, e.ovf);
               end
            end
         end
      end
      start = 1'b0;
      total++;
      if (dones !== 1) begin
         bad++;
         $display("FAIL ign_count got=%0d need 1", dones);
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      bit   to;
      int   dones = 0;
      exp_t e;
      @(negedge clk);
      bin   = 14'd5000;
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      total++;
      if (bcd !== 16'h0 || ovf !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid bcd=%h ovf=%b done=%b need 0000/0/0",
                  bcd, ovf, done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      total++;
      if (dones !== 0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_after dones=%0d ready=%b need 0/1", dones, ready);
      end
      run(5000, lat, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL rst_rerun timeout");
         void'(q.pop_front());
      end else begin
         e = q.pop_front();
         if (bcd !== e.bcd || ovf !== e.ovf) begin
            bad++;
            $display("FAIL rst_rerun got=%h/%b need %h/%b",
                     bcd, ovf, e.bcd, e.ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   n = 0;
      int   last = 0;
      int   cyc = 0;
      exp_t e;
      @(negedge clk);
      bin   = '0;
      start = 1'b1;
      q.push_back(model(0));
      while (n < 100 && cyc < 2500) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            e = q.pop_front();
            total++;
            if (bcd !== e.bcd || ovf !== e.ovf) begin
               bad++;
               $display("FAIL b2b v=%0d got=%h/%b need %h/%b",
                        n, bcd, ovf, e.bcd, e.ovf);
            end
            total++;
            if (cyc - last !== ((n == 0) ? 16 : 17)) begin
               bad++;
               $display("FAIL b2b_gap v=%0d got=%0d", n, cyc - last);
            end
            last = cyc;
            n++;
            if (n < 100) begin
               bin = W'(n);
               q.push_back(model(n));
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      total++;
      if (n !== 100) begin
         bad++;
         $display("FAIL b2b_timeout got=%0d need 100", n);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_values();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (q.size() !== 0) begin
         bad++;
         $display("FAIL queue_left got=%0d need 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
